// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Lets the IF and MEM pipeline stages share one single-port SRAM. Each access
//   runs as issue (one cycle, SRAM strobe driven combinationally from the
//   grant) -> wait (RD_LAT cycles, read data captured on the last edge) ->
//   done (one-cycle completion pulse to the owning port). MEM wins a conflict
//   unless it has already taken DATA_STREAK grants in a row while IF was
//   waiting. In that case IF is forced through so that fetch keeps making progress.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   if_req/if_addr    fetch request (read only)
//   if_rdata/if_done  fetch read data (held) and completion pulse
//   stallreq_if       fetch stall request
//   mem_req/mem_wen/mem_addr/mem_wdata   data request (mem_wen==0 is a read)
//   mem_rdata/mem_done                   data read data (held) and completion pulse
//   stallreq_mem      data stall request
//   sram_en/sram_wen/sram_addr/sram_wdata  macro strobe and command, issue cycle only
//   sram_rdata        macro read data, valid RD_LAT cycles after sram_en
module sram_port_arbiter #(
  parameter int RD_LAT      = 1,
  parameter int DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        stallreq_if,
  input  logic        mem_req,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        stallreq_mem,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("sram_port_arbiter: RD_LAT must be in 1..15");
  end
  if (DATA_STREAK < 1 || DATA_STREAK > 15) begin : g_bad_streak
    $error("sram_port_arbiter: DATA_STREAK must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e      state_q;
  logic        owner_mem_q;   // 1: MEM owns the transaction in flight
  logic        wr_q;          // transaction in flight is a write
  logic [3:0]  cnt_q;
  logic [3:0]  streak_q;      // MEM grants in a row with IF waiting
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        if_done_q;
  logic        mem_done_q;

  logic        if_forced;
  logic        grant_mem;
  logic        issue;

  // IF is forced only when it is actually asking and MEM used up its streak.
  assign if_forced = if_req && (streak_q == 4'(DATA_STREAK));
  assign grant_mem = mem_req && !if_forced;
  // Gated by rst so that nothing leaks onto the macro while reset is held.
  assign issue     = rst && (state_q == S_IDLE) && (if_req || mem_req);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_mem_q <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= 4'd0;
      streak_q    <= 4'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_req || mem_req) begin
            state_q     <= S_WAIT;
            owner_mem_q <= grant_mem;
            wr_q        <= grant_mem && (mem_wen != 4'd0);
            cnt_q       <= 4'(RD_LAT);
            if (grant_mem && if_req) begin
              if (streak_q != 4'(DATA_STREAK)) streak_q <= streak_q + 4'd1;
            end else begin
              streak_q <= 4'd0;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          // cnt_q==1 marks cycle issue+RD_LAT: read data is on the bus now.
          if (cnt_q == 4'd1) begin
            state_q <= S_DONE;
            if (owner_mem_q) begin
              mem_done_q <= 1'b1;
              if (!wr_q) mem_rdata_q <= sram_rdata;
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= sram_rdata;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sram_en    = issue;
  assign sram_addr  = issue ? (grant_mem ? mem_addr : if_addr) : 32'd0;
  assign sram_wen   = (issue && grant_mem) ? mem_wen   : 4'd0;
  assign sram_wdata = (issue && grant_mem) ? mem_wdata : 32'd0;

  // Every output reads as zero while reset is held, even before the edge.
  assign if_done      = rst && if_done_q;
  assign mem_done     = rst && mem_done_q;
  assign if_rdata     = rst ? if_rdata_q  : 32'd0;
  assign mem_rdata    = rst ? mem_rdata_q : 32'd0;
  assign stallreq_if  = rst && if_req  && !if_done;
  assign stallreq_mem = rst && mem_req && !mem_done;

endmodule
